dcache_port_arbiter: RTL and testbench

- Round-robin arbiter sharing the single data-cache request port (cmd/addr/data in, respcyc/resp_data out) between N_REQ memory requesters, e.g. multiple memory pipelines or a future store buffer.
- Sits between the requesters and the data cache.
- Registers the granted request and holds it stable until the cache responds.
- Returns the response to the owner and guarantees at least one NONE cycle on the cache port between transactions.

---
 rtl/dcache_port_arbiter.sv | 133 +++++++++++++
 tb/tb_dcache_port_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter that shares the single data-cache request port among N_REQ requesters.
// The granted request is registered and held until the cache completes it. The response goes back to the owner.
module dcache_port_arbiter #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [2*N_REQ-1:0]       req_cmd,
  input  logic [ADDR_W*N_REQ-1:0]  req_addr,
  input  logic [DATA_W*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]         req_granted,
  output logic [N_REQ-1:0]         resp_valid,
  output logic [DATA_W-1:0]        resp_data,
  output logic [1:0]               ca_req_cmd,
  output logic [ADDR_W-1:0]        ca_req_addr,
  output logic [DATA_W-1:0]        ca_req_data,
  input  logic                     ca_respcyc,
  input  logic [DATA_W-1:0]        ca_resp_data
);

  localparam int unsigned IDX_W    = $clog2(N_REQ);
  localparam logic [1:0]  CMD_NONE = 2'd0;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic [1:0]          ca_cmd_q, ca_cmd_d;
  logic [ADDR_W-1:0]   ca_addr_q, ca_addr_d;
  logic [DATA_W-1:0]   ca_data_q, ca_data_d;

  logic [1:0]          cmd_a  [N_REQ];
  logic [ADDR_W-1:0]   addr_a [N_REQ];
  logic [DATA_W-1:0]   data_a [N_REQ];
  logic                found;
  logic [IDX_W-1:0]    winner;
  logic [IDX_W-1:0]    idx;
  logic [N_REQ-1:0]    owner_oh;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign cmd_a[g]  = req_cmd[2*g +: 2];
    assign addr_a[g] = req_addr[ADDR_W*g +: ADDR_W];
    assign data_a[g] = req_data[DATA_W*g +: DATA_W];
  end

  // The scan starts at rr_ptr and wraps. The first requester found is the winner.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = IDX_W'((32'(rr_ptr_q) + i) % N_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      resp_data_q <= '0;
      ca_cmd_q    <= CMD_NONE;
      ca_addr_q   <= '0;
      ca_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      resp_data_q <= resp_data_d;
      ca_cmd_q    <= ca_cmd_d;
      ca_addr_q   <= ca_addr_d;
      ca_data_q   <= ca_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    resp_data_d = resp_data_q;
    ca_cmd_d    = ca_cmd_q;
    ca_addr_d   = ca_addr_q;
    ca_data_d   = ca_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d   = winner;
          rr_ptr_d  = (32'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
          ca_cmd_d  = cmd_a[winner];
          ca_addr_d = addr_a[winner];
          ca_data_d = data_a[winner];
          // A NONE grant skips the cache. It completes at once with zero data.
          if (cmd_a[winner] == CMD_NONE) begin
            state_d     = S_DONE;
            resp_data_d = '0;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (ca_respcyc) begin
          resp_data_d = ca_resp_data;
          ca_cmd_d    = CMD_NONE;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    req_granted       = (state_q != S_IDLE) ? owner_oh : '0;
    resp_valid        = (state_q == S_DONE) ? owner_oh : '0;
    resp_data         = resp_data_q;
    ca_req_cmd        = ca_cmd_q;
    ca_req_addr       = ca_addr_q;
    ca_req_data       = ca_data_q;
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Table-driven check of dcache_port_arbiter with four requesters, plus an asynchronous reset applied mid-transaction.
module tb_dcache_port_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [2*N-1:0]  req_cmd;
  logic [AW*N-1:0] req_addr;
  logic [DW*N-1:0] req_data;
  logic [N-1:0]    req_granted;
  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_data;
  logic [1:0]      ca_req_cmd;
  logic [AW-1:0]   ca_req_addr;
  logic [DW-1:0]   ca_req_data;
  logic            ca_respcyc;
  logic [DW-1:0]   ca_resp_data;

  int errors = 0;
  int checks = 0;

  dcache_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_cmd      (req_cmd),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_granted  (req_granted),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .ca_req_cmd   (ca_req_cmd),
    .ca_req_addr  (ca_req_addr),
    .ca_req_data  (ca_req_data),
    .ca_respcyc   (ca_respcyc),
    .ca_resp_data (ca_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each row gives the inputs for one cycle and the outputs expected after that edge.
  // lw is the requester whose address and data should be on the cache port.
  typedef struct {
    logic [3:0]  v;
    logic [7:0]  cmd;
    logic        scr;
    logic        rc;
    logic [63:0] rd;
    logic [3:0]  g;
    logic [3:0]  rv;
    logic [63:0] rdat;
    logic [1:0]  cc;
    int          lw;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] v, logic [7:0] cmd, logic scr, logic rc,
                              logic [63:0] rd, logic [3:0] g, logic [3:0] rv,
                              logic [63:0] rdat, logic [1:0] cc, int lw);
    vec_t r;
    r.v = v; r.cmd = cmd; r.scr = scr; r.rc = rc; r.rd = rd;
    r.g = g; r.rv = rv; r.rdat = rdat; r.cc = cc; r.lw = lw;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [7:0] cmd, input logic scr,
                       input logic rc, input logic [63:0] rd);
    req_valid    = v;
    req_cmd      = cmd;
    ca_respcyc   = rc;
    ca_resp_data = rd;
    for (int i = 0; i < int'(N); i++) begin
      req_addr[64*i +: 64] = scr ? 64'hBAD0 + 64'(i) : 64'(i + 1) << 12;
      req_data[64*i +: 64] = scr ? 64'hBEEF : 64'hDA7A_0000 + 64'(i);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " granted"}, 64'(req_granted), 64'h0);
    chk({tag, " resp_valid"}, 64'(resp_valid), 64'h0);
    chk({tag, " resp_data"}, resp_data, 64'h0);
    chk({tag, " ca_cmd"}, 64'(ca_req_cmd), 64'h0);
    chk({tag, " ca_addr"}, ca_req_addr, 64'h0);
    chk({tag, " ca_data"}, ca_req_data, 64'h0);
  endtask

  initial begin
    // single READ on requester 0, then a NONE grant
    tbl.push_back(mk(4'h1, 8'h01, 0, 0, 64'h0,    4'h1, 4'h0, 64'h0,    2'd1, 0));
    tbl.push_back(mk(4'h1, 8'h01, 0, 0, 64'h0,    4'h1, 4'h0, 64'h0,    2'd1, 0));
    tbl.push_back(mk(4'h1, 8'h01, 0, 0, 64'h0,    4'h1, 4'h0, 64'h0,    2'd1, 0));
    tbl.push_back(mk(4'h1, 8'h01, 0, 1, 64'hDEAD, 4'h1, 4'h1, 64'hDEAD, 2'd0, 0));
    tbl.push_back(mk(4'h0, 8'h00, 0, 0, 64'h0,    4'h0, 4'h0, 64'hDEAD, 2'd0, 0));
    tbl.push_back(mk(4'h1, 8'h00, 0, 0, 64'h0,    4'h1, 4'h1, 64'h0,    2'd0, 0));
    tbl.push_back(mk(4'h0, 8'h00, 0, 0, 64'h0,    4'h0, 4'h0, 64'h0,    2'd0, 0));
    // contention: req0 WRITE, req1 READ, both held; rr_ptr=1 so grants go 1,0,1,0
    tbl.push_back(mk(4'h3, 8'h06, 0, 0, 64'h0,    4'h2, 4'h0, 64'h0,    2'd1, 1));
    tbl.push_back(mk(4'h3, 8'h06, 0, 1, 64'h1111, 4'h2, 4'h2, 64'h1111, 2'd0, 1));
    tbl.push_back(mk(4'h3, 8'h06, 0, 0, 64'h0,    4'h0, 4'h0, 64'h1111, 2'd0, 1));
    tbl.push_back(mk(4'h3, 8'h06, 0, 0, 64'h0,    4'h1, 4'h0, 64'h1111, 2'd2, 0));
    tbl.push_back(mk(4'h3, 8'h06, 0, 1, 64'h2222, 4'h1, 4'h1, 64'h2222, 2'd0, 0));
    tbl.push_back(mk(4'h3, 8'h06, 0, 0, 64'h0,    4'h0, 4'h0, 64'h2222, 2'd0, 0));
    tbl.push_back(mk(4'h3, 8'h06, 0, 0, 64'h0,    4'h2, 4'h0, 64'h2222, 2'd1, 1));
    tbl.push_back(mk(4'h3, 8'h06, 0, 1, 64'h3333, 4'h2, 4'h2, 64'h3333, 2'd0, 1));
    tbl.push_back(mk(4'h3, 8'h06, 0, 0, 64'h0,    4'h0, 4'h0, 64'h3333, 2'd0, 1));
    tbl.push_back(mk(4'h3, 8'h06, 0, 0, 64'h0,    4'h1, 4'h0, 64'h3333, 2'd2, 0));
    tbl.push_back(mk(4'h3, 8'h06, 0, 1, 64'h4444, 4'h1, 4'h1, 64'h4444, 2'd0, 0));
    // stray ca_respcyc in DONE, then in IDLE
    tbl.push_back(mk(4'h0, 8'h00, 0, 1, 64'h9999, 4'h0, 4'h0, 64'h4444, 2'd0, 0));
    tbl.push_back(mk(4'h0, 8'h00, 0, 1, 64'h9999, 4'h0, 4'h0, 64'h4444, 2'd0, 0));
    // grant to 2, then 3 and 1 requesting: 3 first, rr_ptr wraps, then 1
    tbl.push_back(mk(4'h4, 8'h10, 0, 0, 64'h0,    4'h4, 4'h0, 64'h4444, 2'd1, 2));
    tbl.push_back(mk(4'h4, 8'h10, 0, 1, 64'h5555, 4'h4, 4'h4, 64'h5555, 2'd0, 2));
    tbl.push_back(mk(4'hA, 8'h84, 0, 0, 64'h0,    4'h0, 4'h0, 64'h5555, 2'd0, 2));
    tbl.push_back(mk(4'hA, 8'h84, 0, 0, 64'h0,    4'h8, 4'h0, 64'h5555, 2'd2, 3));
    tbl.push_back(mk(4'hA, 8'h84, 0, 1, 64'h6666, 4'h8, 4'h8, 64'h6666, 2'd0, 3));
    tbl.push_back(mk(4'h2, 8'h84, 0, 0, 64'h0,    4'h0, 4'h0, 64'h6666, 2'd0, 3));
    tbl.push_back(mk(4'h2, 8'h84, 0, 0, 64'h0,    4'h2, 4'h0, 64'h6666, 2'd1, 1));
    // stability in BUSY: fields scrambled and all valid; then response with new request pending
    tbl.push_back(mk(4'hF, 8'hFF, 1, 0, 64'h0,    4'h2, 4'h0, 64'h6666, 2'd1, 1));
    tbl.push_back(mk(4'hF, 8'hFF, 1, 1, 64'h7777, 4'h2, 4'h2, 64'h7777, 2'd0, 1));
    tbl.push_back(mk(4'h1, 8'h01, 0, 0, 64'h0,    4'h0, 4'h0, 64'h7777, 2'd0, 1));
    tbl.push_back(mk(4'h1, 8'h01, 0, 0, 64'h0,    4'h1, 4'h0, 64'h7777, 2'd1, 0));
    tbl.push_back(mk(4'h1, 8'h01, 0, 1, 64'h8888, 4'h1, 4'h1, 64'h8888, 2'd0, 0));
    tbl.push_back(mk(4'h0, 8'h00, 0, 0, 64'h0,    4'h0, 4'h0, 64'h8888, 2'd0, 0));

    reset = 1'b1;
    drive(4'h0, 8'h00, 0, 0, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    chk_idle_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[k]) begin
      drive(tbl[k].v, tbl[k].cmd, tbl[k].scr, tbl[k].rc, tbl[k].rd);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d granted", k), 64'(req_granted), 64'(tbl[k].g));
      chk($sformatf("row%0d resp_valid", k), 64'(resp_valid), 64'(tbl[k].rv));
      chk($sformatf("row%0d resp_data", k), resp_data, tbl[k].rdat);
      chk($sformatf("row%0d ca_cmd", k), 64'(ca_req_cmd), 64'(tbl[k].cc));
      chk($sformatf("row%0d ca_addr", k), ca_req_addr, 64'(tbl[k].lw + 1) << 12);
      chk($sformatf("row%0d ca_data", k), ca_req_data, 64'hDA7A_0000 + 64'(tbl[k].lw));
      @(negedge clk);
    end

    // reset mid-BUSY, with rr_ptr left at 3 by a grant to requester 2
    drive(4'h4, 8'h20, 0, 0, 64'h0);
    @(posedge clk);
    #1;
    chk("pre-reset ca_cmd", 64'(ca_req_cmd), 64'd2);
    chk("pre-reset granted", 64'(req_granted), 64'h4);
    #3;
    reset = 1'b1;
    #1;
    chk_idle_zero("async reset");
    @(negedge clk);
    reset = 1'b0;
    drive(4'hA, 8'h84, 0, 0, 64'h0);
    @(posedge clk);
    #1;
    chk("post-reset granted", 64'(req_granted), 64'h2);
    chk("post-reset ca_cmd", 64'(ca_req_cmd), 64'd1);
    chk("post-reset ca_addr", ca_req_addr, 64'h2000);
    @(negedge clk);
    drive(4'h0, 8'h00, 0, 0, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
